wm_program_controller: RTL and testbench
========================================

# wm_program_controller

Parametrised washing-machine program sequencer: the next-generation controller after the fixed 3-bit-state machine. It runs a complete wash program with coin credit, internal phase timers replacing the external time-out input, a configurable number of rinse passes, spin retry on imbalance, and latched fault codes. It sits between the coin/lid/sensor inputs and the valve, heater, motor, drain and door-lock actuators.

## Interface
- PRICE_COINS, 2: coins required to start a program (1..15)
- RINSE_PASSES, 2: rinse passes after the main wash (0..7)
- FILL_TIMEOUT, 64: maximum cycles in FILL, HEAT or DRAIN before a fault
- WASH_CYCLES, 128: agitation length in cycles
- SPIN_CYCLES, 64: spin length in cycles
- MAX_RETRY, 2: out-of-balance spin restarts tolerated
- CNT_W, 8: phase-timer width; must hold max(FILL_TIMEOUT, WASH_CYCLES, SPIN_CYCLES)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- sig_Lid_Closed  in  1  lid sensor
- sig_Coin  in  1  one-cycle pulse per coin
- sig_Cancel  in  1  user cancel / fault acknowledge
- sig_Full, sig_Temperature, sig_Empty  in  1 each  level, heat and drain sensors
- sig_Out_Of_Balance, sig_Motor_Failure  in  1 each  drum sensors
- state  out  4  current state encoding
- valve_on, heater_on, motor_on, drain_on, door_lock  out  1 each  actuators
- credit  out  4  coins held
- refund  out  1  one-cycle pulse on cancel in IDLE with credit > 0
- completed  out  1  one-cycle pulse at end of program
- fault_code  out  3  0 none, 1 fill timeout, 2 heat timeout, 3 drain timeout, 4 imbalance, 5 motor, 6 lid opened

## Operation
- States: IDLE 0, FILL 1, HEAT 2, WASH 3, DRAIN 4, SPIN 5, DONE 6, FAULT 7.
- IDLE: each sig_Coin cycle increments credit, saturating at PRICE_COINS. If credit == PRICE_COINS and sig_Lid_Closed, go to FILL and clear credit. sig_Cancel with credit > 0: pulse refund, clear credit.
- FILL: valve_on. On sig_Full go to HEAT on the main pass or to WASH on a rinse pass.
- HEAT: heater_on until sig_Temperature, then WASH.
- WASH: motor_on for exactly WASH_CYCLES cycles, then DRAIN.
- DRAIN: drain_on until sig_Empty. Then go to SPIN, or to IDLE if the abort flag is set.
- SPIN: motor_on and drain_on for SPIN_CYCLES cycles.
  - sig_Out_Of_Balance: restart the timer and increment retry. A retry beyond MAX_RETRY goes to FAULT with code 4.
  - On expiry, if rinse_cnt < RINSE_PASSES, increment rinse_cnt, clear retry, and go to FILL. Otherwise go to DONE.
- DONE: completed=1 for one cycle, then IDLE.
- door_lock=1 in FILL through SPIN. All actuators are 0 in IDLE, DONE and FAULT.
- Timeout: FILL, HEAT or DRAIN held for FILL_TIMEOUT cycles without its exit sensor goes to FAULT with code 1, 2 or 3.
- sig_Cancel in FILL, HEAT or WASH: set abort and go to DRAIN. Cancel is ignored in DRAIN and SPIN. There is no refund after start.
- Priority in FILL..SPIN, highest first: sig_Motor_Failure (code 5), then !sig_Lid_Closed (code 6), then sig_Cancel, then timeout or normal exit.
- FAULT holds fault_code. Exit only on sig_Cancel with sig_Lid_Closed, which returns to IDLE and clears fault_code, rinse_cnt and retry.

## Timing
- All inputs are sampled on the rising clock edge. Transitions take effect on the same edge, so the response latency is 1 cycle.
- Outputs are a Moore decode of the registered state. refund and completed are registered pulses.
- The phase timer clears on every state entry and on a spin restart.
  - WASH lasts exactly WASH_CYCLES cycles. SPIN without imbalance lasts exactly SPIN_CYCLES cycles.
  - A timed-out FILL lasts FILL_TIMEOUT cycles.
  - A sensor asserting on the final timeout cycle wins over the timeout.
- A coin arriving on the same cycle as the start condition is discarded. Coin and cancel arriving together in IDLE: cancel wins and the coin is discarded.
- Reset at any time: state=IDLE and every output=0. credit, rinse_cnt, retry, abort and timer are all cleared.

## Structure
- wm_pkg holds the state encoding, the fault-code constants and the actuator-vector typedef.
- The sub-module wm_phase_timer (clear, enable, terminal-count compare) is parametrised by CNT_W. The top module instantiates it once and drives it with per-state limit values.

## Test plan
- Normal program, PRICE_COINS=2, RINSE_PASSES=1, WASH_CYCLES=8, SPIN_CYCLES=4. Two coins, lid closed, sensors respond after 3 cycles. Required: state sequence 0→1→2→3→4→5→1→3→4→5→6→0, completed pulses once, door_lock=1 throughout 1..5.
- One coin, then cancel in IDLE → refund pulse, credit=0, state stays 0.
- sig_Full never asserts, FILL_TIMEOUT=16 → FAULT on cycle 16 of FILL, fault_code=1. Cancel with lid closed → IDLE, fault_code=0.
- Three imbalance pulses in SPIN with MAX_RETRY=2 → FAULT, fault_code=4. Two pulses only → spin completes normally.
- Lid opened mid-WASH, with cancel asserted on the same cycle → FAULT, fault_code=6 (lid has priority).
- Cancel in HEAT → DRAIN with heater_on=0 and drain_on=1; sig_Empty → IDLE, no completed pulse. Reset asserted mid-SPIN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine program controller.
//   State encoding, fault codes, field widths, and the actuator vector
//   with its Moore decode from a state value.
package wm_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned CREDIT_W = 4;
  localparam int unsigned FAULT_W  = 3;
  localparam int unsigned RINSE_W  = 3;
  localparam int unsigned RETRY_W  = 4;

  localparam logic [STATE_W-1:0] ST_IDLE  = 4'd0;
  localparam logic [STATE_W-1:0] ST_FILL  = 4'd1;
  localparam logic [STATE_W-1:0] ST_HEAT  = 4'd2;
  localparam logic [STATE_W-1:0] ST_WASH  = 4'd3;
  localparam logic [STATE_W-1:0] ST_DRAIN = 4'd4;
  localparam logic [STATE_W-1:0] ST_SPIN  = 4'd5;
  localparam logic [STATE_W-1:0] ST_DONE  = 4'd6;
  localparam logic [STATE_W-1:0] ST_FAULT = 4'd7;

  localparam logic [FAULT_W-1:0] FC_NONE  = 3'd0;
  localparam logic [FAULT_W-1:0] FC_FILL  = 3'd1;
  localparam logic [FAULT_W-1:0] FC_HEAT  = 3'd2;
  localparam logic [FAULT_W-1:0] FC_DRAIN = 3'd3;
  localparam logic [FAULT_W-1:0] FC_BAL   = 3'd4;
  localparam logic [FAULT_W-1:0] FC_MOTOR = 3'd5;
  localparam logic [FAULT_W-1:0] FC_LID   = 3'd6;

  typedef struct packed {
    logic valve;
    logic heater;
    logic motor;
    logic drain;
    logic lock;
  } act_t;

  // Actuators implied by a state; door stays locked for the whole wet program.
  function automatic act_t act_decode(input logic [STATE_W-1:0] st);
    act_t a;
    a = '0;
    case (st)
      ST_FILL:  begin a.valve  = 1'b1; a.lock = 1'b1; end
      ST_HEAT:  begin a.heater = 1'b1; a.lock = 1'b1; end
      ST_WASH:  begin a.motor  = 1'b1; a.lock = 1'b1; end
      ST_DRAIN: begin a.drain  = 1'b1; a.lock = 1'b1; end
      ST_SPIN:  begin a.motor  = 1'b1; a.drain = 1'b1; a.lock = 1'b1; end
      default:  a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Phase timer: counts cycles spent in the current phase.
//   clock, reset : clock and async active-high reset
//   clear_i      : restart from zero (takes priority over enable_i)
//   enable_i     : count this cycle
//   last_i       : terminal count (phase length minus one)
//   tc_c         : combinational, high on the final cycle of the phase
module wm_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_c = enable_i && (cnt_q == last_i);

endmodule

// File: rtl/wm_program_controller.sv
// Washing-machine program sequencer with coin credit, phase timers,
// rinse passes, spin retry on imbalance and latched fault codes.
//   in : clock, reset, sig_Lid_Closed, sig_Coin, sig_Cancel, sig_Full,
//        sig_Temperature, sig_Empty, sig_Out_Of_Balance, sig_Motor_Failure
//   out: state, valve_on, heater_on, motor_on, drain_on, door_lock,
//        credit, refund, completed, fault_code (all registered)
module wm_program_controller
  import wm_pkg::*;
#(
  parameter int unsigned PRICE_COINS  = 2,
  parameter int unsigned RINSE_PASSES = 2,
  parameter int unsigned FILL_TIMEOUT = 64,
  parameter int unsigned WASH_CYCLES  = 128,
  parameter int unsigned SPIN_CYCLES  = 64,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sig_Lid_Closed,
  input  logic                sig_Coin,
  input  logic                sig_Cancel,
  input  logic                sig_Full,
  input  logic                sig_Temperature,
  input  logic                sig_Empty,
  input  logic                sig_Out_Of_Balance,
  input  logic                sig_Motor_Failure,
  output logic [STATE_W-1:0]  state,
  output logic                valve_on,
  output logic                heater_on,
  output logic                motor_on,
  output logic                drain_on,
  output logic                door_lock,
  output logic [CREDIT_W-1:0] credit,
  output logic                refund,
  output logic                completed,
  output logic [FAULT_W-1:0]  fault_code
);

  localparam logic [CNT_W-1:0]    FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    WASH_LAST = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0]    SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] PRICE     = CREDIT_W'(PRICE_COINS);
  localparam logic [RINSE_W-1:0]  RINSES    = RINSE_W'(RINSE_PASSES);
  localparam logic [RETRY_W-1:0]  RETRIES   = RETRY_W'(MAX_RETRY);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [RINSE_W-1:0]  rinse_q, rinse_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                abort_q, abort_d;
  logic [FAULT_W-1:0]  fault_q, fault_d;
  logic                refund_q, refund_d;
  logic                completed_q, completed_d;
  act_t                act_q, act_d;

  logic                restart;
  logic                timer_en, timer_tc;
  logic [CNT_W-1:0]    timer_last;

  // Per-state phase limit; the timer only runs in timed phases.
  always_comb begin
    timer_en   = 1'b0;
    timer_last = FILL_LAST;
    case (state_q)
      ST_FILL, ST_HEAT, ST_DRAIN: timer_en = 1'b1;
      ST_WASH: begin timer_en = 1'b1; timer_last = WASH_LAST; end
      ST_SPIN: begin timer_en = 1'b1; timer_last = SPIN_LAST; end
      default: timer_en = 1'b0;
    endcase
  end

  wm_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear_i  ((state_d != state_q) || restart),
    .enable_i (timer_en),
    .last_i   (timer_last),
    .tc_c     (timer_tc)
  );

  // Next-state and bookkeeping logic.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    rinse_d     = rinse_q;
    retry_d     = retry_q;
    abort_d     = abort_q;
    fault_d     = fault_q;
    refund_d    = 1'b0;
    completed_d = 1'b0;
    restart     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Cancel beats both start and coin; a coin on the start cycle is dropped.
        if (sig_Cancel) begin
          if (credit_q != '0) begin
            refund_d = 1'b1;
            credit_d = '0;
          end
        end else if ((credit_q == PRICE) && sig_Lid_Closed) begin
          state_d  = ST_FILL;
          credit_d = '0;
          rinse_d  = '0;
          retry_d  = '0;
          abort_d  = 1'b0;
        end else if (sig_Coin && (credit_q != PRICE)) begin
          credit_d = credit_q + CREDIT_W'(1);
        end
      end

      ST_FILL, ST_HEAT, ST_WASH, ST_DRAIN, ST_SPIN: begin
        if (sig_Motor_Failure) begin
          state_d = ST_FAULT;
          fault_d = FC_MOTOR;
        end else if (!sig_Lid_Closed) begin
          state_d = ST_FAULT;
          fault_d = FC_LID;
        end else if (sig_Cancel && (state_q != ST_DRAIN) && (state_q != ST_SPIN)) begin
          abort_d = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          // Exit sensors are tested before the timeout so a last-cycle sensor wins.
          case (state_q)
            ST_FILL: begin
              if (sig_Full)      state_d = (rinse_q == '0) ? ST_HEAT : ST_WASH;
              else if (timer_tc) begin state_d = ST_FAULT; fault_d = FC_FILL; end
            end
            ST_HEAT: begin
              if (sig_Temperature) state_d = ST_WASH;
              else if (timer_tc)   begin state_d = ST_FAULT; fault_d = FC_HEAT; end
            end
            ST_WASH: begin
              if (timer_tc) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
              if (sig_Empty) begin
                if (abort_q) begin
                  state_d = ST_IDLE;
                  abort_d = 1'b0;
                  rinse_d = '0;
                  retry_d = '0;
                end else begin
                  state_d = ST_SPIN;
                end
              end else if (timer_tc) begin
                state_d = ST_FAULT;
                fault_d = FC_DRAIN;
              end
            end
            default: begin
              if (sig_Out_Of_Balance) begin
                if (retry_q >= RETRIES) begin
                  state_d = ST_FAULT;
                  fault_d = FC_BAL;
                end else begin
                  retry_d = retry_q + RETRY_W'(1);
                  restart = 1'b1;
                end
              end else if (timer_tc) begin
                if (rinse_q < RINSES) begin
                  rinse_d = rinse_q + RINSE_W'(1);
                  retry_d = '0;
                  state_d = ST_FILL;
                end else begin
                  state_d     = ST_DONE;
                  completed_d = 1'b1;
                end
              end
            end
          endcase
        end
      end

      ST_DONE: state_d = ST_IDLE;

      ST_FAULT: begin
        if (sig_Cancel && sig_Lid_Closed) begin
          state_d = ST_IDLE;
          fault_d = FC_NONE;
          rinse_d = '0;
          retry_d = '0;
          abort_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Actuators are decoded from the next state so they register alongside it.
  always_comb act_d = act_decode(state_d);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      rinse_q     <= '0;
      retry_q     <= '0;
      abort_q     <= 1'b0;
      fault_q     <= FC_NONE;
      refund_q    <= 1'b0;
      completed_q <= 1'b0;
      act_q       <= '0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      rinse_q     <= rinse_d;
      retry_q     <= retry_d;
      abort_q     <= abort_d;
      fault_q     <= fault_d;
      refund_q    <= refund_d;
      completed_q <= completed_d;
      act_q       <= act_d;
    end
  end

  assign state      = state_q;
  assign valve_on   = act_q.valve;
  assign heater_on  = act_q.heater;
  assign motor_on   = act_q.motor;
  assign drain_on   = act_q.drain;
  assign door_lock  = act_q.lock;
  assign credit     = credit_q;
  assign refund     = refund_q;
  assign completed  = completed_q;
  assign fault_code = fault_q;

endmodule

// File: tb/tb_wm_program_controller.sv
// Self-checking bench for wm_program_controller: table of per-cycle
// input/expected records driven through a scoreboard queue, followed by
// a hand-written asynchronous reset in the middle of a spin.
module tb_wm_program_controller;
  import wm_pkg::*;

  localparam int unsigned PRICE = 2;
  localparam int unsigned RINSE = 1;
  localparam int unsigned FTO   = 16;
  localparam int unsigned WASHC = 8;
  localparam int unsigned SPINC = 4;
  localparam int unsigned MAXR  = 2;
  localparam int unsigned CW    = 8;

  // Input bit positions: lid coin cancel full temp empty oob mfail
  localparam logic [7:0] I_LID   = 8'h80;
  localparam logic [7:0] I_COIN  = 8'h40;
  localparam logic [7:0] I_CAN   = 8'h20;
  localparam logic [7:0] I_FULL  = 8'h10;
  localparam logic [7:0] I_TEMP  = 8'h08;
  localparam logic [7:0] I_EMPTY = 8'h04;
  localparam logic [7:0] I_OOB   = 8'h02;
  localparam logic [7:0] I_MF    = 8'h01;

  // Actuators: valve heater motor drain lock
  localparam logic [4:0] A_NONE  = 5'b00000;
  localparam logic [4:0] A_FILL  = 5'b10001;
  localparam logic [4:0] A_HEAT  = 5'b01001;
  localparam logic [4:0] A_WASH  = 5'b00101;
  localparam logic [4:0] A_DRAIN = 5'b00011;
  localparam logic [4:0] A_SPIN  = 5'b00111;

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] act;
    logic [3:0] cr;
    logic       rf;
    logic       cp;
    logic [2:0] fc;
  } exp_t;

  typedef struct {
    logic [7:0] in;
    int         n;
    exp_t       ex;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_v  = 8'h00;

  logic [3:0] state;
  logic       valve_on, heater_on, motor_on, drain_on, door_lock;
  logic [3:0] credit;
  logic       refund, completed;
  logic [2:0] fault_code;

  always #5 clock = ~clock;

  wm_program_controller #(
    .PRICE_COINS(PRICE), .RINSE_PASSES(RINSE), .FILL_TIMEOUT(FTO),
    .WASH_CYCLES(WASHC), .SPIN_CYCLES(SPINC), .MAX_RETRY(MAXR), .CNT_W(CW)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .sig_Lid_Closed     (in_v[7]),
    .sig_Coin           (in_v[6]),
    .sig_Cancel         (in_v[5]),
    .sig_Full           (in_v[4]),
    .sig_Temperature    (in_v[3]),
    .sig_Empty          (in_v[2]),
    .sig_Out_Of_Balance (in_v[1]),
    .sig_Motor_Failure  (in_v[0]),
    .state              (state),
    .valve_on           (valve_on),
    .heater_on          (heater_on),
    .motor_on           (motor_on),
    .drain_on           (drain_on),
    .door_lock          (door_lock),
    .credit             (credit),
    .refund             (refund),
    .completed          (completed),
    .fault_code         (fault_code)
  );

  function automatic exp_t e(input logic [3:0] st, input logic [4:0] act,
                             input logic [3:0] cr = 4'd0, input logic rf = 1'b0,
                             input logic cp = 1'b0, input logic [2:0] fc = 3'd0);
    exp_t x;
    x.st = st; x.act = act; x.cr = cr; x.rf = rf; x.cp = cp; x.fc = fc;
    return x;
  endfunction

  function automatic exp_t actual();
    exp_t x;
    x.st  = state;
    x.act = {valve_on, heater_on, motor_on, drain_on, door_lock};
    x.cr  = credit;
    x.rf  = refund;
    x.cp  = completed;
    x.fc  = fault_code;
    return x;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got st=%0d act=%b cr=%0d rf=%b cp=%b fc=%0d, want st=%0d act=%b cr=%0d rf=%b cp=%b fc=%0d",
               name, got.st, got.act, got.cr, got.rf, got.cp, got.fc,
               want.st, want.act, want.cr, want.rf, want.cp, want.fc);
    end
  endtask

  task automatic add(input logic [7:0] in, input int n, input exp_t ex);
    vec_t v;
    v.in = in; v.n = n; v.ex = ex;
    vecs.push_back(v);
  endtask

  // Two coins then start with the lid closed.
  task automatic start_rows();
    add(I_LID | I_COIN, 1, e(ST_IDLE, A_NONE, 4'd1));
    add(I_LID | I_COIN, 1, e(ST_IDLE, A_NONE, 4'd2));
    add(I_LID,          1, e(ST_FILL, A_FILL));
  endtask

  // From a main-pass FILL to SPIN; cancel during DRAIN must be ignored.
  task automatic to_spin_rows();
    add(I_LID | I_FULL,  1,              e(ST_HEAT,  A_HEAT));
    add(I_LID | I_TEMP,  1,              e(ST_WASH,  A_WASH));
    add(I_LID,           int'(WASHC) - 1, e(ST_WASH,  A_WASH));
    add(I_LID,           1,              e(ST_DRAIN, A_DRAIN));
    add(I_LID | I_CAN,   1,              e(ST_DRAIN, A_DRAIN));
    add(I_LID | I_EMPTY, 1,              e(ST_SPIN,  A_SPIN));
  endtask

  initial begin
    exp_t want;

    // Reset state
    reset = 1'b1;
    in_v  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", actual(), e(ST_IDLE, A_NONE));
    reset = 1'b0;

    // Normal program: main pass plus one rinse, sensors after 3 cycles
    add(8'h00, 1, e(ST_IDLE, A_NONE));
    start_rows();
    add(I_LID,           2,              e(ST_FILL,  A_FILL));
    add(I_LID | I_FULL,  1,              e(ST_HEAT,  A_HEAT));
    add(I_LID,           2,              e(ST_HEAT,  A_HEAT));
    add(I_LID | I_TEMP,  1,              e(ST_WASH,  A_WASH));
    add(I_LID,           int'(WASHC) - 1, e(ST_WASH,  A_WASH));
    add(I_LID,           1,              e(ST_DRAIN, A_DRAIN));
    add(I_LID,           2,              e(ST_DRAIN, A_DRAIN));
    add(I_LID | I_EMPTY, 1,              e(ST_SPIN,  A_SPIN));
    add(I_LID,           int'(SPINC) - 1, e(ST_SPIN,  A_SPIN));
    add(I_LID,           1,              e(ST_FILL,  A_FILL));
    add(I_LID,           2,              e(ST_FILL,  A_FILL));
    add(I_LID | I_FULL,  1,              e(ST_WASH,  A_WASH));
    add(I_LID,           int'(WASHC) - 1, e(ST_WASH,  A_WASH));
    add(I_LID,           1,              e(ST_DRAIN, A_DRAIN));
    add(I_LID,           2,              e(ST_DRAIN, A_DRAIN));
    add(I_LID | I_EMPTY, 1,              e(ST_SPIN,  A_SPIN));
    add(I_LID,           int'(SPINC) - 1, e(ST_SPIN,  A_SPIN));
    add(I_LID,           1,              e(ST_DONE,  A_NONE, 4'd0, 1'b0, 1'b1));
    add(I_LID,           1,              e(ST_IDLE,  A_NONE));

    // Refund, cancel-beats-coin, saturation, start drops coin, fill timeout
    add(I_LID | I_COIN,         1, e(ST_IDLE, A_NONE, 4'd1));
    add(I_LID | I_CAN,          1, e(ST_IDLE, A_NONE, 4'd0, 1'b1));
    add(I_LID,                  1, e(ST_IDLE, A_NONE));
    add(I_LID | I_COIN | I_CAN, 1, e(ST_IDLE, A_NONE));
    add(I_COIN,                 1, e(ST_IDLE, A_NONE, 4'd1));
    add(I_COIN,                 2, e(ST_IDLE, A_NONE, 4'd2));
    add(I_LID | I_COIN,         1, e(ST_FILL, A_FILL));
    add(I_LID,          int'(FTO) - 1, e(ST_FILL,  A_FILL));
    add(I_LID,                  1, e(ST_FAULT, A_NONE, 4'd0, 1'b0, 1'b0, FC_FILL));
    add(I_LID,                  2, e(ST_FAULT, A_NONE, 4'd0, 1'b0, 1'b0, FC_FILL));
    add(I_CAN,                  1, e(ST_FAULT, A_NONE, 4'd0, 1'b0, 1'b0, FC_FILL));
    add(I_LID | I_CAN,          1, e(ST_IDLE,  A_NONE));

    // Three imbalance pulses exceed the retry budget
    start_rows();
    to_spin_rows();
    add(I_LID | I_OOB, 1, e(ST_SPIN,  A_SPIN));
    add(I_LID,         1, e(ST_SPIN,  A_SPIN));
    add(I_LID | I_OOB, 1, e(ST_SPIN,  A_SPIN));
    add(I_LID | I_OOB, 1, e(ST_FAULT, A_NONE, 4'd0, 1'b0, 1'b0, FC_BAL));
    add(I_LID | I_CAN, 1, e(ST_IDLE,  A_NONE));

    // Two pulses: spin restarts and completes; then lid opens in WASH with cancel
    start_rows();
    to_spin_rows();
    add(I_LID | I_OOB, 1,              e(ST_SPIN,  A_SPIN));
    add(I_LID,         2,              e(ST_SPIN,  A_SPIN));
    add(I_LID | I_OOB, 1,              e(ST_SPIN,  A_SPIN));
    add(I_LID,         int'(SPINC) - 1, e(ST_SPIN,  A_SPIN));
    add(I_LID,         1,              e(ST_FILL,  A_FILL));
    add(I_LID | I_FULL, 1,             e(ST_WASH,  A_WASH));
    add(I_LID,         2,              e(ST_WASH,  A_WASH));
    add(I_CAN,         1,              e(ST_FAULT, A_NONE, 4'd0, 1'b0, 1'b0, FC_LID));
    add(I_LID | I_CAN, 1,              e(ST_IDLE,  A_NONE));

    // Sensor on the final timeout cycle wins; cancel in HEAT aborts via DRAIN
    start_rows();
    add(I_LID,           int'(FTO) - 1, e(ST_FILL,  A_FILL));
    add(I_LID | I_FULL,  1,            e(ST_HEAT,  A_HEAT));
    add(I_LID,           1,            e(ST_HEAT,  A_HEAT));
    add(I_LID | I_CAN,   1,            e(ST_DRAIN, A_DRAIN));
    add(I_LID,           2,            e(ST_DRAIN, A_DRAIN));
    add(I_LID | I_EMPTY, 1,            e(ST_IDLE,  A_NONE));
    add(I_LID,           1,            e(ST_IDLE,  A_NONE));

    // Motor failure outranks lid-open and cancel
    start_rows();
    add(I_CAN | I_MF,  1, e(ST_FAULT, A_NONE, 4'd0, 1'b0, 1'b0, FC_MOTOR));
    add(I_LID | I_CAN, 1, e(ST_IDLE,  A_NONE));

    // Reach SPIN for the asynchronous reset below
    start_rows();
    to_spin_rows();
    add(I_LID, 1, e(ST_SPIN, A_SPIN));

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        in_v = vecs[i].in;
        sb.push_back(vecs[i].ex);
        @(posedge clock);
        #1;
        want = sb.pop_front();
        check($sformatf("vec%0d.%0d", i, k), actual(), want);
      end
    end

    // Asynchronous reset mid-SPIN, away from any clock edge
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", actual(), e(ST_IDLE, A_NONE));
    @(posedge clock);
    #1;
    check("reset_hold", actual(), e(ST_IDLE, A_NONE));
    reset = 1'b0;
    in_v  = I_LID | I_COIN;
    @(posedge clock);
    #1;
    check("post_reset_coin", actual(), e(ST_IDLE, A_NONE, 4'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
